// File: rtl/uart_tx_drain_if.sv
// rtl/uart_tx_drain_if.sv - FIFO-side and serial-side signals of the UART drain transmitter
interface uart_tx_drain_if #(
   parameter int bit_width = 8
);
   logic                 can_read;
   logic [bit_width-1:0] read_data;
   logic                 read;
   logic                 tx;
   logic                 busy;

   // FIFO / line side: supplies the head word, observes pop strobe and serial line
   modport master (
      output can_read,
      output read_data,
      input  read,
      input  tx,
      input  busy
   );

   // Transmitter side
   modport slave (
      input  can_read,
      input  read_data,
      output read,
      output tx,
      output busy
   );
endinterface

// File: rtl/uart_tx_drain.sv
// rtl/uart_tx_drain.sv - UART transmitter that pops words from a FIFO and serialises them
module uart_tx_drain #(
   parameter int bit_width   = 8,
   parameter int baud_div    = 104,
   parameter int parity_mode = 0,
   parameter int stop_bits   = 1
) (
   input  logic           clk,
   input  logic           rst,
   uart_tx_drain_if.slave bus
);
   localparam int CW = (baud_div > 1) ? $clog2(baud_div) : 1;
   localparam int BW = $clog2(bit_width + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [CW-1:0]        r_cnt;
   logic [BW-1:0]        r_bit;
   logic [bit_width-1:0] r_shift;
   logic                 r_par;
   logic                 r_tx;
   logic                 r_busy;
   logic                 w_bit_end;
   logic                 w_last_data;
   logic                 w_last_stop;
   logic                 w_read;
   logic                 w_tx_next;

   assign w_bit_end   = (r_cnt == CW'(baud_div - 1));
   assign w_last_data = (r_bit == BW'(bit_width - 1));
   assign w_last_stop = (r_bit == BW'(stop_bits - 1));

   assign bus.read = w_read;
   assign bus.tx   = r_tx;
   assign bus.busy = r_busy;

   // State register; reset abandons any frame in flight
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Baud counter, bit index, shift register and registered line outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         r_tx   <= w_tx_next;
         r_busy <= (w_next_state != S_IDLE);
         // Counter restarts on every state entry so no partial bit carries over
         if (w_next_state != r_state || w_bit_end || r_state == S_IDLE) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         // Bit index counts data bits in DATA and stop bits in STOP
         if (w_next_state != r_state) begin
            r_bit <= '0;
         end else if (w_bit_end && (r_state == S_DATA || r_state == S_STOP)) begin
            r_bit <= r_bit + 1'b1;
         end
         // Head word is combinational from the FIFO, so capture it on the pop edge
         if (w_read) begin
            r_shift <= bus.read_data;
            r_par   <= ^bus.read_data;
         end else if (r_state == S_DATA && w_bit_end) begin
            r_shift <= r_shift >> 1;
         end
      end
   end

   // Next-state decode of the frame sequence
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (bus.can_read) w_next_state = S_START;
         S_START:  if (w_bit_end) w_next_state = S_DATA;
         S_DATA:   if (w_bit_end && w_last_data)
                      w_next_state = (parity_mode != 0) ? S_PARITY : S_STOP;
         S_PARITY: if (w_bit_end) w_next_state = S_STOP;
         S_STOP:   if (w_bit_end && w_last_stop) w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // Pop strobe from the registered state, and the line level for the coming cycle
   always_comb begin
      w_read    = rst && (r_state == S_IDLE) && bus.can_read;
      w_tx_next = 1'b1;
      case (w_next_state)
         S_START:  w_tx_next = 1'b0;
         S_DATA:   w_tx_next = (r_state == S_DATA && w_bit_end) ? r_shift[1] : r_shift[0];
         S_PARITY: w_tx_next = (parity_mode == 2) ? ~r_par : r_par;
         default:  w_tx_next = 1'b1;
      endcase
   end
endmodule

// File: tb/tb_uart_tx_drain.sv
// tb/tb_uart_tx_drain.sv - scoreboard bench for uart_tx_drain over four frame formats
`timescale 1ns/1ps
module tb_uart_tx_drain;
   localparam int NCFG = 4;
   localparam int BAUD = 4;

   logic       clk;
   logic       rst;
   bit         rst_at_edge;
   logic [3:0] all_idle;
   int         n_checks;
   int         n_fail;
   logic [7:0] fifo_q [NCFG][$];
   logic [7:0] exp_q  [NCFG][$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) rst_at_edge <= !rst;

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push_all(input logic [7:0] b);
      for (int k = 0; k < NCFG; k++) begin
         fifo_q[k].push_back(b);
         exp_q[k].push_back(b);
      end
   endtask

   task automatic wait_all_idle(input int max);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (all_idle != 4'hF && n < max);
      chk(all_idle == 4'hF, "drain_within_bound", int'(all_idle), 15);
      repeat (2) @(negedge clk);
   endtask

   for (genvar g = 0; g < NCFG; g++) begin : g_cfg
      localparam int PM = (g == 1) ? 1 : (g == 2) ? 2 : 0;
      localparam int SB = (g == 3) ? 2 : 1;

      uart_tx_drain_if #(.bit_width(8)) u_if ();

      uart_tx_drain #(
         .bit_width  (8),
         .baud_div   (BAUD),
         .parity_mode(PM),
         .stop_bits  (SB)
      ) u_dut (
         .clk(clk),
         .rst(rst),
         .bus(u_if)
      );

      assign all_idle[g] = !u_if.busy && !u_if.can_read;

      // FIFO model: pops on a sampled read strobe, presents head combinationally
      initial begin
         logic pop_pend;
         u_if.can_read  = 1'b0;
         u_if.read_data = 8'h00;
         forever begin
            @(negedge clk);
            pop_pend = u_if.read;
            @(posedge clk);
            #1;
            if (pop_pend === 1'b1 && fifo_q[g].size() != 0) void'(fifo_q[g].pop_front());
            #1;
            u_if.can_read  = (fifo_q[g].size() != 0);
            u_if.read_data = (fifo_q[g].size() != 0) ? fifo_q[g][0] : 8'h00;
         end
      end

      // Monitor: idle cycles between frames, and a full expected frame after each pop
      initial begin
         bit         bits[$];
         logic [7:0] d;
         bit         pending;
         pending = 1'b0;
         repeat (2) @(posedge clk);
         forever begin
            if (!pending) @(negedge clk);
            pending = 1'b0;
            chk(u_if.tx === 1'b1, $sformatf("cfg%0d_idle_tx", g), int'(u_if.tx), 1);
            chk(u_if.busy === 1'b0, $sformatf("cfg%0d_idle_busy", g), int'(u_if.busy), 0);
            chk(u_if.read === (rst && u_if.can_read), $sformatf("cfg%0d_idle_read", g),
                int'(u_if.read), int'(rst && u_if.can_read));
            if (u_if.read === 1'b1) begin
               chk(exp_q[g].size() != 0, $sformatf("cfg%0d_read_has_word", g), exp_q[g].size(), 1);
               if (exp_q[g].size() != 0) begin
                  d = exp_q[g].pop_front();
                  bits.delete();
                  bits.push_back(1'b0);
                  for (int i = 0; i < 8; i++) bits.push_back(d[i]);
                  if (PM != 0) bits.push_back((PM == 1) ? ^d : ~^d);
                  for (int s = 0; s < SB; s++) bits.push_back(1'b1);
                  for (int c = 0; c < bits.size() * BAUD; c++) begin
                     @(negedge clk);
                     if (rst_at_edge) begin
                        pending = 1'b1;
                        break;
                     end
                     chk(u_if.tx === bits[c / BAUD],
                         $sformatf("cfg%0d_byte%02h_bit%0d_cyc%0d_tx", g, d, c / BAUD, c),
                         int'(u_if.tx), int'(bits[c / BAUD]));
                     chk(u_if.busy === 1'b1, $sformatf("cfg%0d_frame_busy_cyc%0d", g, c),
                         int'(u_if.busy), 1);
                     chk(u_if.read === 1'b0, $sformatf("cfg%0d_frame_read_cyc%0d", g, c),
                         int'(u_if.read), 0);
                  end
               end
            end
         end
      end
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      repeat (200) @(posedge clk);

      #1 push_all(8'h55);
      wait_all_idle(200);

      @(posedge clk);
      #1 push_all(8'hA5);
      push_all(8'h3C);
      wait_all_idle(300);

      @(posedge clk);
      #1 push_all(8'h07);
      push_all(8'hFF);
      wait_all_idle(300);

      // Reset during data bit 3 of 0x00; 0x5A must follow as a clean new frame
      @(posedge clk);
      #1 push_all(8'h00);
      push_all(8'h5A);
      repeat (18) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      wait_all_idle(300);

      for (int r = 0; r < 24; r++) begin
         repeat ($urandom_range(0, 40)) @(posedge clk);
         #1 push_all(8'($urandom_range(0, 255)));
         if ($urandom_range(0, 3) == 0) push_all(8'($urandom_range(0, 255)));
      end
      wait_all_idle(4000);

      for (int k = 0; k < NCFG; k++) begin
         chk(exp_q[k].size() == 0, $sformatf("cfg%0d_all_words_sent", k), exp_q[k].size(), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
